// File: rtl/frame_buffer_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
//   Shared constants and types for the frame buffer arbiter:
//   - default frame geometry (IMG_WIDTH x IMG_HEIGHT), FB_DEPTH and FB_LAST
//   - frame buffer address/data widths and write FIFO depth
//   - grant encoding used by the arbiter each cycle
//   - fb_depth(): pixel count for a given geometry
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int IMG_WIDTH   = 320;
  localparam int IMG_HEIGHT  = 240;
  localparam int FB_DEPTH    = IMG_WIDTH * IMG_HEIGHT;
  localparam int FB_LAST     = FB_DEPTH - 1;
  localparam int ADDR_W      = 17;
  localparam int DATA_W      = 8;
  localparam int WFIFO_DEPTH = 16;

  // Which requester owns the BRAM port in a given cycle.
  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } gnt_e;

  function automatic int fb_depth(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// ---------------------------------------------------------------------------
// frame_buffer_arbiter_if
//   Bundles every non-clock/reset signal of the arbiter.
//   Write stream : wr_valid, wr_data, wr_sof in; wr_ready out
//   Read stream  : rd_req, rd_sof in; rd_data, rd_valid out
//   BRAM port    : mem_en, mem_we, mem_addr, mem_wdata out; mem_rdata in
//   Status       : frame_done (pulse), overflow (sticky)
//   slave  = arbiter side, master = environment (Sobel / VGA / BRAM) side.
// ---------------------------------------------------------------------------
interface frame_buffer_arbiter_if #(
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W
);

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_sof;
  logic              wr_ready;

  logic              rd_req;
  logic              rd_sof;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              frame_done;
  logic              overflow;

  modport slave (
    input  wr_valid, wr_data, wr_sof, rd_req, rd_sof, mem_rdata,
    output wr_ready, rd_data, rd_valid, mem_en, mem_we, mem_addr, mem_wdata,
           frame_done, overflow
  );

  modport master (
    output wr_valid, wr_data, wr_sof, rd_req, rd_sof, mem_rdata,
    input  wr_ready, rd_data, rd_valid, mem_en, mem_we, mem_addr, mem_wdata,
           frame_done, overflow
  );

endinterface

// File: rtl/frame_buffer_arbiter_wr_fifo.sv
// ---------------------------------------------------------------------------
// fb_wr_fifo
//   Synchronous show-ahead FIFO holding pending frame buffer writes.
//   clk, rst : clock, asynchronous active-high reset
//   push_i   : write din_i (ignored while full)
//   din_i    : entry to store
//   pop_i    : discard head entry (ignored while empty)
//   dout_o   : current head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy status
// ---------------------------------------------------------------------------
module fb_wr_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Pointers wrap naturally only for a power-of-two depth.
  if ((1 << PTR_W) != DEPTH) begin : g_depth_chk
    $error("fb_wr_fifo: DEPTH=%0d must be a power of 2", DEPTH);
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  always_comb begin
    // NOTE: every _d signal gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; count and pointers alone decide
  // which entries are valid, and an unreset array can map onto RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: clocked blocks use <= so every flop samples pre-edge values;
  // blocking = is kept to always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// frame_buffer_arbiter
//   Shares one single-port, registered-output frame buffer BRAM between the
//   Sobel writer (cannot stall, buffered in a FIFO) and the VGA reader (one
//   pixel per clock, absolute priority). Writes drain in read gaps.
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : frame_buffer_arbiter_if.slave
//     wr_valid/wr_data/wr_sof -> FIFO push; wr_ready = FIFO not full
//     rd_req/rd_sof           -> BRAM read; rd_data/rd_valid two clocks later
//     mem_*                   -> registered BRAM port
//     frame_done              -> pulse with the write of the last pixel
//     overflow                -> sticky, a pixel was dropped on a full FIFO
// ---------------------------------------------------------------------------
module frame_buffer_arbiter #(
  parameter int IMG_WIDTH   = fb_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT  = fb_pkg::IMG_HEIGHT,
  parameter int ADDR_W      = fb_pkg::ADDR_W,
  parameter int DATA_W      = fb_pkg::DATA_W,
  parameter int WFIFO_DEPTH = fb_pkg::WFIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_buffer_arbiter_if.slave bus
);

  import fb_pkg::*;

  localparam int DEPTH = fb_depth(IMG_WIDTH, IMG_HEIGHT);
  localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;

  if ($clog2(DEPTH) > ADDR_W) begin : g_addr_w_chk
    $error("frame_buffer_arbiter: ADDR_W=%0d cannot address %0d pixels", ADDR_W, DEPTH);
  end

  // Safe after the width check above: the last address always fits.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] pix;
  } wr_entry_t;

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Write FIFO
  wr_entry_t        push_entry, pop_entry;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push, pop;

  assign push_entry = '{sof: bus.wr_sof, pix: bus.wr_data};
  assign push       = bus.wr_valid & ~fifo_full;

  fb_wr_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (WFIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (pop_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Held low while rst is asserted so every output reads 0 during reset;
  // otherwise purely the occupancy count.
  assign bus.wr_ready = ~rst & (fifo_count != CNT_W'(WFIFO_DEPTH));

  // Registered state
  logic              mem_en_q,     mem_en_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [ADDR_W-1:0] rd_addr_q,    rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic              sof_pend_q,   sof_pend_d;
  logic [1:0]        rd_pipe_q,    rd_pipe_d;
  logic              rd_valid_q,   rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,    rd_data_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q,   overflow_d;

  // Grant: reads always win, writes take any cycle the reader leaves free.
  gnt_e gnt;

  always_comb begin
    gnt = GNT_IDLE;
    if (bus.rd_req)       gnt = GNT_READ;
    else if (!fifo_empty) gnt = GNT_WRITE;
  end

  assign pop = (gnt == GNT_WRITE);

  // Address used by this cycle's access, if granted. A start-of-frame
  // (live or pending) forces address 0.
  logic [ADDR_W-1:0] rd_cur, wr_cur;

  assign rd_cur = (bus.rd_sof | sof_pend_q) ? '0 : rd_addr_q;
  assign wr_cur = pop_entry.sof             ? '0 : wr_addr_q;

  always_comb begin
    mem_en_d     = (gnt != GNT_IDLE);
    mem_we_d     = (gnt == GNT_WRITE);
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    sof_pend_d   = sof_pend_q;
    frame_done_d = 1'b0;

    case (gnt)
      GNT_READ: begin
        mem_addr_d = rd_cur;
        rd_addr_d  = addr_next(rd_cur);
        sof_pend_d = 1'b0;
      end
      GNT_WRITE: begin
        mem_addr_d   = wr_cur;
        mem_wdata_d  = pop_entry.pix;
        wr_addr_d    = addr_next(wr_cur);
        frame_done_d = (wr_cur == LAST_ADDR);
      end
      default: ;
    endcase

    // rd_sof without a read is remembered for the next read.
    if (gnt != GNT_READ && bus.rd_sof) sof_pend_d = 1'b1;

    // Stage 0 marks a read on mem_*, stage 1 the cycle mem_rdata is valid,
    // after which it is captured onto rd_data.
    rd_pipe_d  = {rd_pipe_q[0], (gnt == GNT_READ)};
    rd_valid_d = rd_pipe_q[1];
    rd_data_d  = rd_pipe_q[1] ? bus.mem_rdata : rd_data_q;

    // A push attempt against a full FIFO is lost even if a pop frees a slot
    // in the same cycle.
    overflow_d = overflow_q | (bus.wr_valid & fifo_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      sof_pend_q   <= 1'b0;
      rd_pipe_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      sof_pend_q   <= sof_pend_d;
      rd_pipe_q    <= rd_pipe_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_arbiter
//   Drives the arbiter with a reduced 320x8 frame, models the BRAM, and
//   scoreboards expected read addresses, read data and write transactions.
// ---------------------------------------------------------------------------
module tb_frame_buffer_arbiter;

  localparam int TB_W  = 320;
  localparam int TB_H  = 8;
  localparam int NPIX  = TB_W * TB_H;
  localparam int LAST  = NPIX - 1;
  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int FD    = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  frame_buffer_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  frame_buffer_arbiter #(
    .IMG_WIDTH   (TB_W),
    .IMG_HEIGHT  (TB_H),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WFIFO_DEPTH (FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // BRAM model: single port, registered read data.
  logic [DW-1:0] bram [2**AW];
  logic [DW-1:0] bram_rdata = '0;

  assign bus.mem_rdata = bram_rdata;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
      else            bram_rdata         <= bram[bus.mem_addr];
    end
  end

  // Reference models and scoreboards
  int            rd_addr_m, wr_addr_m, cnt_m;
  bit            sof_pend_m;
  logic [AW-1:0] rd_exp_q[$];
  logic [DW-1:0] rdat_exp_q[$];
  logic [AW-1:0] wa_exp_q[$];
  logic [DW-1:0] wd_exp_q[$];
  bit            chk_en = 1'b0;
  int            wr_seen = 0, fd_seen = 0, rv_seen = 0;
  bit [1:0]      vpipe = '0;

  task automatic reset_models();
    rd_addr_m = 0; wr_addr_m = 0; cnt_m = 0; sof_pend_m = 1'b0;
    rd_exp_q.delete(); rdat_exp_q.delete(); wa_exp_q.delete(); wd_exp_q.delete();
    vpipe = '0;
  endtask

  // Monitor: samples registered outputs on the falling edge.
  always @(negedge clk) begin : mon
    logic [AW-1:0] a;
    if (chk_en && !rst) begin
      check("rd_valid_timing", {31'd0, bus.rd_valid}, {31'd0, vpipe[1]});
      if (bus.rd_valid) begin
        rv_seen++;
        if (rdat_exp_q.size() == 0) check("rd_data_unexpected", 1, 0);
        else check("rd_data", bus.rd_data, rdat_exp_q.pop_front());
      end
      vpipe = {vpipe[0], bus.mem_en & ~bus.mem_we};
      if (bus.mem_en && !bus.mem_we) begin
        if (rd_exp_q.size() == 0) check("read_unexpected", 1, 0);
        else begin
          a = rd_exp_q.pop_front();
          check("rd_addr", bus.mem_addr, a);
          rdat_exp_q.push_back(bram[a]);
        end
      end
      if (bus.mem_en && bus.mem_we) begin
        wr_seen++;
        if (wa_exp_q.size() == 0) check("write_unexpected", 1, 0);
        else begin
          a = wa_exp_q.pop_front();
          check("wr_addr", bus.mem_addr, a);
          check("wr_data", bus.mem_wdata, wd_exp_q.pop_front());
          check("frame_done", {31'd0, bus.frame_done}, {31'd0, (int'(a) == LAST)});
        end
      end else begin
        check("frame_done_idle", {31'd0, bus.frame_done}, 0);
      end
      if (bus.frame_done) fd_seen++;
    end
  end

  // One clock of stimulus; models what the next edge should do.
  task automatic cyc(input bit wv, input logic [DW-1:0] wd, input bit ws,
                     input bit rq, input bit rs);
    int a;
    bit push_m, pop_m;
    bus.wr_valid = wv; bus.wr_data = wd; bus.wr_sof = ws;
    bus.rd_req   = rq; bus.rd_sof  = rs;
    check("wr_ready", {31'd0, bus.wr_ready}, {31'd0, (cnt_m < FD)});
    if (rq) begin
      a = (rs || sof_pend_m) ? 0 : rd_addr_m;
      rd_exp_q.push_back(AW'(a));
      rd_addr_m  = (a == LAST) ? 0 : a + 1;
      sof_pend_m = 1'b0;
    end else if (rs) begin
      sof_pend_m = 1'b1;
    end
    pop_m  = !rq && (cnt_m > 0);
    push_m = wv && (cnt_m < FD);
    if (push_m) begin
      a = ws ? 0 : wr_addr_m;
      wa_exp_q.push_back(AW'(a));
      wd_exp_q.push_back(wd);
      wr_addr_m = (a == LAST) ? 0 : a + 1;
    end
    cnt_m = cnt_m + int'(push_m) - int'(pop_m);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_outputs_zero(input string ph);
    check({ph, "_mem_en"},     {31'd0, bus.mem_en},     0);
    check({ph, "_mem_we"},     {31'd0, bus.mem_we},     0);
    check({ph, "_mem_addr"},   bus.mem_addr,            0);
    check({ph, "_mem_wdata"},  bus.mem_wdata,           0);
    check({ph, "_rd_valid"},   {31'd0, bus.rd_valid},   0);
    check({ph, "_rd_data"},    bus.rd_data,             0);
    check({ph, "_frame_done"}, {31'd0, bus.frame_done}, 0);
    check({ph, "_overflow"},   {31'd0, bus.overflow},   0);
    check({ph, "_wr_ready"},   {31'd0, bus.wr_ready},   0);
  endtask

  task automatic check_drained(input string ph);
    check({ph, "_pending"},
          rd_exp_q.size() + rdat_exp_q.size() + wa_exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int w0, r0, f0;
    for (int a = 0; a < 2**AW; a++) bram[a] = DW'((a * 7 + 3) ^ (a >> 5));
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_sof = 1'b0;
    bus.rd_req   = 1'b0; bus.rd_sof  = 1'b0;
    reset_models();

    // Reset state
    #1;
    check_outputs_zero("reset");
    #21 rst = 1'b0;
    #1 check("reset_wr_ready", {31'd0, bus.wr_ready}, 1);
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Idle read line: rd_sof + rd_req, 320 reads from address 0
    r0 = rv_seen;
    for (int i = 0; i < TB_W; i++) cyc(1'b0, '0, 1'b0, 1'b1, (i == 0));
    idle(3);
    check("line_rd_valid_count", rv_seen - r0, TB_W);
    check_drained("line");

    // Write drain: 10 writes, sof on the first, no reads
    w0 = wr_seen;
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'($urandom_range(0, 255)), (i == 0), 1'b0, 1'b0);
    idle(3);
    check("drain_writes", wr_seen - w0, 10);
    check_drained("drain");

    // Contention: 40 reads, 20 writes arriving in the first 20 cycles
    w0 = wr_seen;
    for (int i = 0; i < 40; i++) cyc((i < 20), DW'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
    check("cont_no_write_during_read", wr_seen - w0, 0);
    check("cont_overflow", {31'd0, bus.overflow}, 1);
    check("cont_wr_ready_full", {31'd0, bus.wr_ready}, 0);
    idle(16);
    @(negedge clk); #1;
    check("cont_drained_16", wr_seen - w0, 16);
    @(posedge clk); #1;
    check("cont_wr_ready_back", {31'd0, bus.wr_ready}, 1);
    idle(3);
    check("cont_overflow_sticky", {31'd0, bus.overflow}, 1);
    check_drained("cont");

    // Deferred rd_sof: sof alone, 3 idle cycles, then reads from 0
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(3);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(3);
    check_drained("defer");

    // Wrap: full frame written, one extra non-sof write lands at 0
    f0 = fd_seen;
    for (int i = 0; i < NPIX; i++) cyc(1'b1, DW'($urandom_range(0, 255)), (i == 0), 1'b0, 1'b0);
    cyc(1'b1, 8'h5a, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("wrap_frame_done_once", fd_seen - f0, 1);
    check_drained("wrap_wr");

    // Read address wrap: full frame plus one read, back at address 0
    r0 = rv_seen;
    for (int i = 0; i < NPIX + 1; i++) cyc(1'b0, '0, 1'b0, 1'b1, (i == 0));
    idle(3);
    check("wrap_rd_count", rv_seen - r0, NPIX + 1);
    check_drained("wrap_rd");

    // Reset mid-stream: 5 writes queued behind reads, reads in flight
    for (int i = 0; i < 8; i++) cyc((i < 5), DW'(i + 1), 1'b0, 1'b1, 1'b0);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    bus.wr_valid = 1'b0; bus.rd_req = 1'b0; bus.rd_sof = 1'b0; bus.wr_sof = 1'b0;
    #1;
    check_outputs_zero("midrst");
    reset_models();
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check("midrst_wr_ready", {31'd0, bus.wr_ready}, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_rd_valid", {31'd0, bus.rd_valid}, 0);
      check("midrst_no_access",   {31'd0, bus.mem_en},   0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
